npc_unit: RTL and testbench
===========================

# npc_unit

Fetch-side PC sequencer for the five-stage MIPS core. It consumes the D-stage equality flag produced by the register comparator, together with D-stage branch/jump decode, and drives the F-stage PC and the F/D PC register. It also handles one architectural delay slot, exception entry and `eret` redirection. It sits between the instruction memory address port and the F/D pipeline register.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `EXC_PC`, default 32'h0000_4180: exception/interrupt handler entry.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `stall` input 1: freeze F and D (hazard unit).
- `req` input 1: exception/interrupt request from CP0; flush and redirect.
- `eret_d` input 1: `eret` decoded in D.
- `epc` input 32: CP0 EPC value.
- `br_type_d` input 3: 0 none, 1 beq, 2 bne, 3 j/jal, 4 jr/jalr; 5–7 are treated as none.
- `zero` input 1: comparator result, 1 when the D-stage rs and rt values are equal.
- `imm16_d` input 16: branch offset.
- `index26_d` input 26: jump index.
- `rs_val_d` input 32: forwarded rs value for jr/jalr.
- `pc_f` output 32: fetch address (registered).
- `pc_d` output 32: PC of the D-stage instruction (registered).
- `valid_d` output 1: D slot holds a real instruction (0 means bubble/flushed).
- `bd_d` output 1: D-stage instruction is in a branch delay slot.
- `adel_f` output 1: fetch address error (see Configuration).

## Operation
- Target computation, combinational from D inputs:
  - beq/bne: `pc_d + 4 + {sext(imm16_d), 2'b00}`, 32-bit wraparound.
  - j: `{pc_d_plus4[31:28], index26_d, 2'b00}`.
  - jr: `rs_val_d`, unmodified; misalignment is reported through `adel_f`.
- Taken:
  - beq taken when `zero` = 1.
  - bne taken when `zero` = 0.
  - j and jr are always taken.
  - All branch types are taken only when `valid_d` = 1.
- Per-edge update, in strict priority order:
  1. `req`:
     - `pc_f` <= EXC_PC.
     - `pc_d` <= 0, `valid_d` <= 0, `bd_d` <= 0.
     - `req` overrides `stall`.
  2. `stall`: hold `pc_f`, `pc_d`, `valid_d` and `bd_d`.
  3. `eret_d && valid_d`:
     - `pc_f` <= epc.
     - D is flushed: `valid_d` <= 0, `bd_d` <= 0, `pc_d` <= 0.
     - `eret` has no delay slot.
  4. Taken branch/jump:
     - `pc_f` <= target.
     - `pc_d` <= pc_f, `valid_d` <= 1.
     - The delay slot proceeds.
  5. Otherwise:
     - `pc_f` <= pc_f + 4.
     - `pc_d` <= pc_f, `valid_d` <= 1.
- `bd_d` on a normal advance (cases 4 and 5) <= (`valid_d` && `br_type_d` ∈ {1,2,3,4}), independent of taken.
- Not-taken branch: sequential advance; the delay slot still carries `bd_d` = 1.
- `eret_d` and a branch type both asserted: `eret` wins.

## Timing
- Reset values:
  - `pc_f` = RESET_PC.
  - `pc_d` = 0, `valid_d` = 0, `bd_d` = 0.
  - `adel_f` = 0 while `pc_f` = RESET_PC.
- Branch resolution happens in D, one edge after fetch. Exactly one delay-slot instruction follows, with zero bubbles.
- `zero`, `rs_val_d` and the D decode inputs must be stable before the edge. The unit does not register them.
- Stall on consecutive cycles holds indefinitely. A branch held in D re-evaluates the target each cycle and uses the value at the releasing edge.
- `adel_f` is combinational from `pc_f`. It is valid in the same cycle as `pc_f`.

## Configuration
- `NPC_FETCH_CHECK_EN` defined:
  - `adel_f` = 1 when `pc_f[1:0]` ≠ 0, or when `pc_f` lies outside [32'h0000_3000, 32'h0000_6FFC].
  - The PC still advances as normal. CP0 is expected to raise `req`.
- `NPC_FETCH_CHECK_EN` not defined: `adel_f` is tied to 0 and the compare logic is absent.

## Test plan
- Reset mid-run with `pc_f` = 32'h3010 → immediately `pc_f` = 32'h3000, `valid_d` = 0. After the first edge: `pc_f` = 32'h3004, `pc_d` = 32'h3000, `valid_d` = 1.
- beq at `pc_d` = 32'h3008, `imm16_d` = 16'hFFFE, `zero` = 1 → next edge `pc_f` = 32'h3004, `pc_d` = 32'h300C, `bd_d` = 1. Same setup with `zero` = 0 → `pc_f` = 32'h3010, `bd_d` = 1.
- jr with `rs_val_d` = 32'h0000_3402 under NPC_FETCH_CHECK_EN → `pc_f` = 32'h3402, `adel_f` = 1. Without the macro → `adel_f` = 0.
- `stall` = 1 for 3 cycles with beq in D, `zero` toggling → `pc_f` and `pc_d` frozen. On release with `zero` = 1 → branch taken.
- `req` and `stall` together, `pc_f` = 32'h3020 → `pc_f` = 32'h4180, `valid_d` = 0, `bd_d` = 0.
- `eret_d` = 1 with `br_type_d` = 1 and `epc` = 32'h3050 → `pc_f` = 32'h3050, `valid_d` = 0 (no delay slot).

Source files
------------

// File: rtl/npc_unit.sv
// Fetch-side PC sequencer: delay-slot branches/jumps, exception entry and eret redirect.
// Optional fetch address check enabled by defining NPC_FETCH_CHECK_EN.
module npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic [2:0]  br_type_d,
    input  logic        zero,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] rs_val_d,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic        adel_f
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_J    = 3'd3,
        BR_JR   = 3'd4
    } br_type_e;

    logic [31:0] pc_d_plus4;
    logic [31:0] br_offset;
    logic [31:0] target;
    logic        taken;
    logic        is_branch;

    assign pc_d_plus4 = pc_d + 32'd4;
    assign br_offset  = {{14{imm16_d[15]}}, imm16_d, 2'b00};

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        target    = pc_d_plus4 + br_offset;
        taken     = 1'b0;
        is_branch = 1'b0;
        case (br_type_e'(br_type_d))
            BR_BEQ: begin
                taken     = zero;
                is_branch = 1'b1;
            end
            BR_BNE: begin
                taken     = ~zero;
                is_branch = 1'b1;
            end
            BR_J: begin
                target    = {pc_d_plus4[31:28], index26_d, 2'b00};
                taken     = 1'b1;
                is_branch = 1'b1;
            end
            BR_JR: begin
                target    = rs_val_d;
                taken     = 1'b1;
                is_branch = 1'b1;
            end
            default: ;
        endcase
        // A bubble in D must never redirect fetch or mark a delay slot.
        taken     = taken & valid_d;
        is_branch = is_branch & valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            bd_d    <= 1'b0;
        end else if (req) begin
            pc_f    <= EXC_PC;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            bd_d    <= 1'b0;
        end else if (stall) begin
            pc_f    <= pc_f;
            pc_d    <= pc_d;
            valid_d <= valid_d;
            bd_d    <= bd_d;
        end else if (eret_d && valid_d) begin
            // eret has no delay slot: the instruction behind it is squashed.
            pc_f    <= epc;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            bd_d    <= 1'b0;
        end else begin
            pc_f    <= taken ? target : pc_f + 32'd4;
            pc_d    <= pc_f;
            valid_d <= 1'b1;
            bd_d    <= is_branch;
        end
    end

`ifdef NPC_FETCH_CHECK_EN
    assign adel_f = (pc_f[1:0] != 2'b00) ||
                    (pc_f < 32'h0000_3000) || (pc_f > 32'h0000_6FFC);
`else
    assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: stimulus pushes expected state, monitor pops and compares.
// Reference model is a plain next-state calculation over the architectural PC rules.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, req, eret_d, zero;
    logic [31:0] epc, rs_val_d;
    logic [2:0]  br_type_d;
    logic [15:0] imm16_d;
    logic [25:0] index26_d;
    logic [31:0] pc_f, pc_d;
    logic        valid_d, bd_d, adel_f;

    npc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret_d(eret_d),
        .epc(epc), .br_type_d(br_type_d), .zero(zero), .imm16_d(imm16_d),
        .index26_d(index26_d), .rs_val_d(rs_val_d), .pc_f(pc_f), .pc_d(pc_d),
        .valid_d(valid_d), .bd_d(bd_d), .adel_f(adel_f)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic        valid_d;
        logic        bd_d;
    } exp_t;

    exp_t sb_q[$];
    logic [31:0] m_pc_f, m_pc_d;
    logic        m_valid, m_bd;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_adel(input logic [31:0] pc);
`ifdef NPC_FETCH_CHECK_EN
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc_f  = 32'h3000;
        m_pc_d  = 32'h0;
        m_valid = 1'b0;
        m_bd    = 1'b0;
    endtask

    // Called just after a falling edge: applies inputs, predicts the next edge, waits a cycle.
    task automatic drive(input logic st, input logic rq, input logic er, input logic [31:0] ep,
                         input logic [2:0] bt, input logic z, input logic [15:0] im,
                         input logic [25:0] ix, input logic [31:0] rs);
        exp_t e;
        logic [31:0] tgt;
        logic taken, is_br;
        int off;
        stall = st; req = rq; eret_d = er; epc = ep; br_type_d = bt;
        zero = z; imm16_d = im; index26_d = ix; rs_val_d = rs;
        if (rq) begin
            e = '{32'h4180, 32'h0, 1'b0, 1'b0};
        end else if (st) begin
            e = '{m_pc_f, m_pc_d, m_valid, m_bd};
        end else if (er && m_valid) begin
            e = '{ep, 32'h0, 1'b0, 1'b0};
        end else begin
            off   = $signed(im);
            is_br = m_valid && bt >= 3'd1 && bt <= 3'd4;
            taken = m_valid && ((bt == 3'd1 && z) || (bt == 3'd2 && !z) ||
                                bt == 3'd3 || bt == 3'd4);
            if (bt == 3'd3)      tgt = ((m_pc_d + 32'd4) & 32'hF000_0000) | (32'(ix) * 32'd4);
            else if (bt == 3'd4) tgt = rs;
            else                 tgt = m_pc_d + 32'd4 + 32'(off * 4);
            e = '{(taken ? tgt : m_pc_f + 32'd4), m_pc_f, 1'b1, is_br};
        end
        sb_q.push_back(e);
        m_pc_f = e.pc_f; m_pc_d = e.pc_d; m_valid = e.valid_d; m_bd = e.bd_d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted from a falling edge, checked before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        model_reset();
        #1;
        check({tag, "_rst_pc_f"}, pc_f, 32'h3000);
        check({tag, "_rst_valid"}, {31'b0, valid_d}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every active edge that had stimulus predicted gets compared just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_pc_f", pc_f, e.pc_f);
            check("sb_pc_d", pc_d, e.pc_d);
            check("sb_valid_d", {31'b0, valid_d}, {31'b0, e.valid_d});
            check("sb_bd_d", {31'b0, bd_d}, {31'b0, e.bd_d});
            check("sb_adel_f", {31'b0, adel_f}, {31'b0, exp_adel(e.pc_f)});
        end
    end

    initial begin
        reset = 1'b1;
        stall = 0; req = 0; eret_d = 0; epc = 0; br_type_d = 0;
        zero = 0; imm16_d = 0; index26_d = 0; rs_val_d = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pc_f", pc_f, 32'h3000);
        check("reset_pc_d", pc_d, 32'h0);
        check("reset_valid_bd", {30'b0, valid_d, bd_d}, 32'h0);
        check("reset_adel", {31'b0, adel_f}, 32'h0);
        reset = 1'b0;

        // Mid-run reset from pc_f = 3010
        idle(4);
        check("pre_reset_pc_f", pc_f, 32'h3010);
        do_reset("mid");
        idle(1);
        check("first_pc_f", pc_f, 32'h3004);
        check("first_pc_d", pc_d, 32'h3000);
        check("first_valid", {31'b0, valid_d}, 32'h1);

        // beq taken at pc_d = 3008, offset -2 words
        idle(2);
        drive(0, 0, 0, 0, 3'd1, 1'b1, 16'hFFFE, 0, 0);
        check("beq_t_pc_f", pc_f, 32'h3004);
        check("beq_t_pc_d", pc_d, 32'h300C);
        check("beq_t_bd", {31'b0, bd_d}, 32'h1);

        // beq not taken
        do_reset("bnt");
        idle(3);
        drive(0, 0, 0, 0, 3'd1, 1'b0, 16'hFFFE, 0, 0);
        check("beq_nt_pc_f", pc_f, 32'h3010);
        check("beq_nt_bd", {31'b0, bd_d}, 32'h1);

        // Stall with beq in D, zero toggling; taken on release
        do_reset("stl");
        idle(3);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 3'd1, 1'(i), 16'hFFFE, 0, 0);
        check("stall_pc_f", pc_f, 32'h300C);
        check("stall_pc_d", pc_d, 32'h3008);
        drive(0, 0, 0, 0, 3'd1, 1'b1, 16'hFFFE, 0, 0);
        check("stall_rel_pc_f", pc_f, 32'h3004);

        // req overrides stall at pc_f = 3020
        do_reset("req");
        idle(8);
        check("pre_req_pc_f", pc_f, 32'h3020);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("req_pc_f", pc_f, 32'h4180);
        check("req_valid_bd", {30'b0, valid_d, bd_d}, 32'h0);

        // eret wins over beq, no delay slot
        do_reset("ert");
        idle(2);
        drive(0, 0, 1, 32'h3050, 3'd1, 1'b1, 16'h0004, 0, 0);
        check("eret_pc_f", pc_f, 32'h3050);
        check("eret_valid", {31'b0, valid_d}, 32'h0);
        idle(1);

        // jr to a misaligned address
        do_reset("jr");
        idle(2);
        drive(0, 0, 0, 0, 3'd4, 0, 0, 0, 32'h0000_3402);
        check("jr_pc_f", pc_f, 32'h3402);
`ifdef NPC_FETCH_CHECK_EN
        check("jr_adel", {31'b0, adel_f}, 32'h1);
`else
        check("jr_adel", {31'b0, adel_f}, 32'h0);
`endif
        idle(1);

        // Randomized traffic
        do_reset("rnd");
        for (int i = 0; i < 500; i++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? $urandom() :
                 (32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFC));
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 30) == 0,
                  $urandom_range(0, 15) == 0, 32'h3000 + ($urandom_range(0, 255) * 4),
                  3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom),
                  26'($urandom), rs);
        end

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
